// File: rtl/main_fsm.sv
// main_fsm: multicycle main control FSM for the RISC-V core.
// Sequences the shared datapath (PC, IR, register file, single ALU, unified
// memory) through fetch/decode/execute/memory/writeback and stalls on the
// memory-ready handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   op, funct3            instruction fields from the instruction register
//   Zero                  ALU zero flag (branch compare)
//   mem_ready             memory finished the current access this cycle
//   IRWrite, PCWrite      IR / PC load enables (combinationally gated)
//   RegWrite, MemWrite    register file / memory write enables
//   AdrSrc                memory address select (0 PC, 1 ALUOut)
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ResultSrc, ImmSrc     result mux select, immediate format
//   ALUD, F               ALU decoder control (ALUD=0 forces ADD)
//   illegal               one-cycle pulse on an unsupported opcode
//   instr_done            high in the last cycle of every instruction
//   state                 current state encoding (debug)
module main_fsm #(
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [6:0]     op,
  input  logic [2:0]     funct3,
  input  logic           Zero,
  input  logic           mem_ready,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           RegWrite,
  output logic           MemWrite,
  output logic           AdrSrc,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ResultSrc,
  output logic [1:0]     ImmSrc,
  output logic           ALUD,
  output logic [2:0]     F,
  output logic           illegal,
  output logic           instr_done,
  output logic [STW-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // State-decoded (Moore) outputs, held in registers.
  typedef struct packed {
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       alud;
    logic [2:0] f;
    logic       reg_write;
    logic       mem_write;
  } moore_t;

  state_t state_q, state_d;
  moore_t mo_q;

  // op/funct3 come from the IR, which is stable from the end of FETCH until
  // the next FETCH completes, so sampling them at the transition edge is safe.
  function automatic moore_t moore_dec(state_t s, logic [6:0] opc, logic [2:0] f3);
    moore_t m;
    m = '0;
    case (s)
      FETCH:    begin m.alu_src_b = 2'b10; m.result_src = 2'b10; end
      DECODE:   begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b01; m.imm_src = 2'b10; end
      MEMADR:   begin
                  m.alu_src_a = 2'b10; m.alu_src_b = 2'b01;
                  m.imm_src   = (opc == OP_SW) ? 2'b01 : 2'b00;
                end
      MEMREAD:  m.adr_src = 1'b1;
      MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; end
      MEMWRITE: begin m.adr_src = 1'b1; m.mem_write = 1'b1; end
      EXECR:    begin m.alu_src_a = 2'b10; m.alud = 1'b1; m.f = f3; end
      EXECI:    begin
                  m.alu_src_a = 2'b10; m.alu_src_b = 2'b01;
                  m.alud = 1'b1; m.f = f3;
                end
      ALUWB:    m.reg_write = 1'b1;
      BEQ:      begin m.alu_src_a = 2'b10; m.alud = 1'b1; m.f = 3'b100; end
      JAL:      begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b10; end
      default:  m = '0;
    endcase
    return m;
  endfunction

  function automatic logic op_legal(logic [6:0] opc);
    return (opc == OP_LW) || (opc == OP_SW) || (opc == OP_R) ||
           (opc == OP_I)  || (opc == OP_BEQ) || (opc == OP_JAL);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE:   begin
                  case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                  endcase
                end
      MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Output registers are loaded with the decode of the next state, so they
  // line up with state_q and need no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      mo_q    <= moore_dec(FETCH, 7'd0, 3'd0);
    end else begin
      state_q <= state_d;
      mo_q    <= moore_dec(state_d, op, funct3);
    end
  end

  // Handshake/flag-dependent enables; rst_n gating keeps them quiet while the
  // FSM is parked in FETCH under reset.
  assign IRWrite    = rst_n && (state_q == FETCH) && mem_ready;
  assign PCWrite    = rst_n && (((state_q == FETCH) && mem_ready) ||
                                ((state_q == BEQ) && Zero) ||
                                (state_q == JAL));
  assign illegal    = rst_n && (state_q == DECODE) && !op_legal(op);
  assign instr_done = rst_n && ((state_q == MEMWB) || (state_q == ALUWB) ||
                                (state_q == BEQ) ||
                                ((state_q == MEMWRITE) && mem_ready) ||
                                ((state_q == DECODE) && !op_legal(op)));

  assign RegWrite  = mo_q.reg_write;
  assign MemWrite  = mo_q.mem_write;
  assign AdrSrc    = mo_q.adr_src;
  assign ALUSrcA   = mo_q.alu_src_a;
  assign ALUSrcB   = mo_q.alu_src_b;
  assign ResultSrc = mo_q.result_src;
  assign ImmSrc    = mo_q.imm_src;
  assign ALUD      = mo_q.alud;
  assign F         = mo_q.f;
  assign state     = STW'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       mem_ready;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       ALUD;
  logic [2:0] F;
  logic       illegal, instr_done;
  logic [3:0] state;
  logic [5:0] en;

  int nvec = 0;
  int nerr = 0;

  main_fsm #(.STW(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .Zero(Zero),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUD(ALUD), .F(F), .illegal(illegal),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  // {IRWrite, PCWrite, RegWrite, MemWrite, illegal, instr_done}
  assign en = {IRWrite, PCWrite, RegWrite, MemWrite, illegal, instr_done};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    mem_ready = 1'b1;
    #1;
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL reset state: got %0d want 0", state); end
    nvec++; if (en !== 6'b0) begin nerr++; $display("FAIL reset enables: got %b want 000000", en); end
    nvec++; if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== {1'b0, 2'b00, 2'b10, 2'b10}) begin
      nerr++; $display("FAIL reset fetch_sel: got %b want 000001010", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    end
    mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    nvec++; if (en !== 6'b0) begin nerr++; $display("FAIL release_stall enables: got %b want 000000", en); end
    mem_ready = 1'b1;
    #1;
    nvec++; if (en !== 6'b110000) begin nerr++; $display("FAIL release_first enables: got %b want 110000", en); end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL release_hold state: got %0d want 0", state); end
  endtask

  task automatic test_rtype(input logic [2:0] f3);
    logic [3:0] es[4];
    logic [5:0] ee[4];
    es = '{4'd0, 4'd1, 4'd6, 4'd8};
    ee = '{6'b110000, 6'b000000, 6'b000000, 6'b001001};
    op = 7'b0110011; funct3 = f3;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #3;
      nvec++; if (state !== es[i]) begin nerr++; $display("FAIL rtype state c%0d: got %0d want %0d", i, state, es[i]); end
      nvec++; if (en !== ee[i]) begin nerr++; $display("FAIL rtype enables c%0d: got %b want %b", i, en, ee[i]); end
      if (i == 2) begin
        nvec++; if ({ALUD, F, ALUSrcA, ALUSrcB} !== {1'b1, f3, 2'b10, 2'b00}) begin
          nerr++; $display("FAIL rtype execr_ctl: got %b want %b", {ALUD, F, ALUSrcA, ALUSrcB}, {1'b1, f3, 2'b10, 2'b00});
        end
      end
      @(posedge clk); #1;
    end
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL rtype end state: got %0d want 0", state); end
  endtask

  task automatic test_itype(input logic [2:0] f3);
    logic [3:0] es[4];
    logic [5:0] ee[4];
    es = '{4'd0, 4'd1, 4'd7, 4'd8};
    ee = '{6'b110000, 6'b000000, 6'b000000, 6'b001001};
    op = 7'b0010011; funct3 = f3;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #3;
      nvec++; if (state !== es[i]) begin nerr++; $display("FAIL itype state c%0d: got %0d want %0d", i, state, es[i]); end
      nvec++; if (en !== ee[i]) begin nerr++; $display("FAIL itype enables c%0d: got %b want %b", i, en, ee[i]); end
      if (i == 2) begin
        nvec++; if ({ALUD, F, ALUSrcA, ALUSrcB, ImmSrc} !== {1'b1, f3, 2'b10, 2'b01, 2'b00}) begin
          nerr++; $display("FAIL itype execi_ctl: got %b want %b", {ALUD, F, ALUSrcA, ALUSrcB, ImmSrc}, {1'b1, f3, 2'b10, 2'b01, 2'b00});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] es[10];
    logic [5:0] ee[10];
    logic       mr[10];
    es = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    ee = '{6'b0, 6'b0, 6'b110000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b001001};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 10; i++) begin
      mem_ready = mr[i]; #3;
      nvec++; if (state !== es[i]) begin nerr++; $display("FAIL lw state c%0d: got %0d want %0d", i, state, es[i]); end
      nvec++; if (en !== ee[i]) begin nerr++; $display("FAIL lw enables c%0d: got %b want %b", i, en, ee[i]); end
      if (i == 4) begin
        nvec++; if ({ALUSrcA, ALUSrcB, ImmSrc} !== 6'b100100) begin
          nerr++; $display("FAIL lw memadr_ctl: got %b want 100100", {ALUSrcA, ALUSrcB, ImmSrc});
        end
      end
      if (i == 5) begin
        nvec++; if ({AdrSrc, ResultSrc} !== 3'b100) begin
          nerr++; $display("FAIL lw memread_ctl: got %b want 100", {AdrSrc, ResultSrc});
        end
      end
      if (i == 9) begin
        nvec++; if (ResultSrc !== 2'b01) begin
          nerr++; $display("FAIL lw memwb_result: got %b want 01", ResultSrc);
        end
      end
      @(posedge clk); #1;
    end
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL lw end state: got %0d want 0", state); end
  endtask

  task automatic test_sw();
    logic [3:0] es[5];
    logic [5:0] ee[5];
    logic       mr[5];
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    ee = '{6'b110000, 6'b0, 6'b0, 6'b000100, 6'b000101};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #3;
      nvec++; if (state !== es[i]) begin nerr++; $display("FAIL sw state c%0d: got %0d want %0d", i, state, es[i]); end
      nvec++; if (en !== ee[i]) begin nerr++; $display("FAIL sw enables c%0d: got %b want %b", i, en, ee[i]); end
      if (i == 2) begin
        nvec++; if (ImmSrc !== 2'b01) begin nerr++; $display("FAIL sw memadr_imm: got %b want 01", ImmSrc); end
      end
      if (i == 3) begin
        nvec++; if (AdrSrc !== 1'b1) begin nerr++; $display("FAIL sw adrsrc: got %b want 1", AdrSrc); end
      end
      @(posedge clk); #1;
    end
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL sw end state: got %0d want 0", state); end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0] es[3];
    logic [5:0] ee[3];
    es = '{4'd0, 4'd1, 4'd9};
    ee = '{6'b110000, 6'b0, z ? 6'b010001 : 6'b000001};
    op = 7'b1100011; funct3 = 3'b000; Zero = z;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #3;
      nvec++; if (state !== es[i]) begin nerr++; $display("FAIL beq%0d state c%0d: got %0d want %0d", z, i, state, es[i]); end
      nvec++; if (en !== ee[i]) begin nerr++; $display("FAIL beq%0d enables c%0d: got %b want %b", z, i, en, ee[i]); end
      if (i == 1) begin
        nvec++; if ({ALUSrcA, ALUSrcB, ImmSrc} !== 6'b010110) begin
          nerr++; $display("FAIL beq decode_ctl: got %b want 010110", {ALUSrcA, ALUSrcB, ImmSrc});
        end
      end
      if (i == 2) begin
        nvec++; if ({ALUD, F, ALUSrcA, ALUSrcB} !== 8'b1_100_10_00) begin
          nerr++; $display("FAIL beq cmp_ctl: got %b want 11001000", {ALUD, F, ALUSrcA, ALUSrcB});
        end
      end
      @(posedge clk); #1;
    end
    Zero = 1'b0;
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL beq end state: got %0d want 0", state); end
  endtask

  task automatic test_jal();
    logic [3:0] es[4];
    logic [5:0] ee[4];
    es = '{4'd0, 4'd1, 4'd10, 4'd8};
    ee = '{6'b110000, 6'b0, 6'b010000, 6'b001001};
    op = 7'b1101111; funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #3;
      nvec++; if (state !== es[i]) begin nerr++; $display("FAIL jal state c%0d: got %0d want %0d", i, state, es[i]); end
      nvec++; if (en !== ee[i]) begin nerr++; $display("FAIL jal enables c%0d: got %b want %b", i, en, ee[i]); end
      if (i == 2) begin
        nvec++; if ({ALUD, ALUSrcA, ALUSrcB} !== 5'b0_01_10) begin
          nerr++; $display("FAIL jal ctl: got %b want 00110", {ALUD, ALUSrcA, ALUSrcB});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [3:0] es[2];
    logic [5:0] ee[2];
    es = '{4'd0, 4'd1};
    ee = '{6'b110000, 6'b000011};
    op = 7'b1111111; funct3 = 3'b000;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1; #3;
      nvec++; if (state !== es[i]) begin nerr++; $display("FAIL illegal state c%0d: got %0d want %0d", i, state, es[i]); end
      nvec++; if (en !== ee[i]) begin nerr++; $display("FAIL illegal enables c%0d: got %b want %b", i, en, ee[i]); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #3;
    nvec++; if ({state, en} !== {4'd0, 6'b0}) begin
      nerr++; $display("FAIL illegal after: got state %0d en %b want 0 000000", state, en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    op = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #2;
    nvec++; if (state !== 4'd3) begin nerr++; $display("FAIL midreset pre state: got %0d want 3", state); end
    mem_ready = 1'b1;
    rst_n = 1'b0; #1;
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL midreset state: got %0d want 0", state); end
    nvec++; if (en !== 6'b0) begin nerr++; $display("FAIL midreset enables: got %b want 000000", en); end
    nvec++; if ({AdrSrc, ALUSrcB, ResultSrc} !== 5'b0_10_10) begin
      nerr++; $display("FAIL midreset sel: got %b want 01010", {AdrSrc, ALUSrcB, ResultSrc});
    end
    mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++; if (state !== 4'd0) begin nerr++; $display("FAIL midreset release: got %0d want 0", state); end
  endtask

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; Zero = 1'b0; mem_ready = 1'b0;
    #12;
    test_reset();
    test_rtype(3'b000);
    test_rtype(3'b100);
    test_itype(3'b110);
    test_lw_stall();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
